// File: rtl/order_dispatch_arbiter_if.sv
// Order dispatch bus: the parser request channels, the shared order-book
// command bus and the arbiter status outputs, carried as one bundle.
//   slave  : seen from the arbiter. It receives requests and book_ready, and
//            drives req_ready, book_valid, the payload and the status flags.
//   master : seen from the environment (parsers, books, testbench).
// Packing of the request vectors:
//   req_order_id / req_quantity : requester i at [32i+31:32i]
//   req_price                   : requester i at [64i+63:64i]
//   req_stock_activate          : requester i at [3*NUM_BOOKS*i +: 3*NUM_BOOKS].
//                                 Within a slice, book k uses bits
//                                 {add,delete,decrease} at [3(NUM_BOOKS-1-k) +: 3],
//                                 so book 0 sits in the MSBs.
interface order_dispatch_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_BOOKS = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*32-1:0]          req_order_id;
    logic [NUM_REQ*32-1:0]          req_quantity;
    logic [NUM_REQ*64-1:0]          req_price;
    logic [NUM_REQ*3*NUM_BOOKS-1:0] req_stock_activate;

    logic [NUM_BOOKS-1:0]           book_valid;
    logic [NUM_BOOKS-1:0]           book_ready;
    logic [31:0]                    out_order_id;
    logic [31:0]                    out_quantity;
    logic [63:0]                    out_price;
    logic [2:0]                     out_op;

    logic [GW-1:0]                  grant_id;
    logic                           busy;
    logic                           illegal_err;
    logic                           timeout_err;

    modport slave (
        input  req_valid, req_order_id, req_quantity, req_price,
               req_stock_activate, book_ready,
        output req_ready, book_valid, out_order_id, out_quantity, out_price,
               out_op, grant_id, busy, illegal_err, timeout_err
    );

    modport master (
        output req_valid, req_order_id, req_quantity, req_price,
               req_stock_activate, book_ready,
        input  req_ready, book_valid, out_order_id, out_quantity, out_price,
               out_op, grant_id, busy, illegal_err, timeout_err
    );
endinterface

// File: rtl/order_dispatch_arbiter.sv
// Round-robin arbiter that shares the order-book command bus between
// NUM_REQ message parsers. A winner's command is checked for a single
// active {add,delete,decrease} bit, presented to the addressed book with
// book_valid until book_ready (or TIMEOUT cycles), and the winner then gets
// a one-cycle req_ready. illegal_err / timeout_err pulse together with it.
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : order_dispatch_arbiter_if.slave (requests, book bus, status)
module order_dispatch_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_BOOKS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    order_dispatch_arbiter_if.slave    bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int AW = 3 * NUM_BOOKS;
    localparam logic [GW:0]          NREQ_W   = (GW+1)'(NUM_REQ);
    localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0]   REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]            state;
    logic [GW-1:0]         rr_ptr;
    logic [15:0]           wait_cnt;

    logic [2*NUM_REQ-1:0]  rot_valid;
    logic [GW-1:0]         win_off;
    logic [GW:0]           win_sum;
    logic                  any_valid;
    logic [GW-1:0]         win_idx;
    logic [GW-1:0]         next_ptr;
    logic [31:0]           win_oid;
    logic [31:0]           win_qty;
    logic [63:0]           win_price;
    logic [AW-1:0]         win_act;
    logic [NUM_BOOKS-1:0]  win_books;
    logic [2:0]            win_op;
    logic                  win_legal;
    logic                  book_hit;

    // Rotate the valid vector so that rr_ptr lands at bit 0; the lowest set
    // bit is then the round-robin winner, offset from rr_ptr.
    always_comb begin
        rot_valid = {bus.req_valid, bus.req_valid} >> rr_ptr;
        any_valid = 1'b0;
        win_off   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && rot_valid[i]) begin
                any_valid = 1'b1;
                win_off   = GW'(i);
            end
        end
        win_sum  = {1'b0, rr_ptr} + {1'b0, win_off};
        win_idx  = (win_sum >= NREQ_W) ? GW'(win_sum - NREQ_W) : GW'(win_sum);
        next_ptr = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        win_oid   = '0;
        win_qty   = '0;
        win_price = '0;
        win_act   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_oid   = bus.req_order_id[32*i +: 32];
                win_qty   = bus.req_quantity[32*i +: 32];
                win_price = bus.req_price[64*i +: 64];
                win_act   = bus.req_stock_activate[AW*i +: AW];
            end
        end
    end

    // Book 0 occupies the top triplet of the activate slice.
    always_comb begin
        win_books = '0;
        win_op    = '0;
        for (int unsigned k = 0; k < NUM_BOOKS; k++) begin
            win_books[k] = |win_act[3*(NUM_BOOKS-1-k) +: 3];
            win_op       = win_op | win_act[3*(NUM_BOOKS-1-k) +: 3];
        end
        win_legal = $onehot(win_act);
    end

    // Only the addressed book's ready counts.
    always_comb begin
        book_hit = |(bus.book_valid & bus.book_ready);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            wait_cnt         <= '0;
            bus.req_ready    <= '0;
            bus.book_valid   <= '0;
            bus.out_order_id <= '0;
            bus.out_quantity <= '0;
            bus.out_price    <= '0;
            bus.out_op       <= '0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
            bus.illegal_err  <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            // req_ready and error flags are pulses that live only in ACK.
            bus.req_ready   <= '0;
            bus.illegal_err <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.out_order_id <= win_oid;
                        bus.out_quantity <= win_qty;
                        bus.out_price    <= win_price;
                        bus.grant_id     <= win_idx;
                        rr_ptr           <= next_ptr;
                        bus.busy         <= 1'b1;
                        if (win_legal) begin
                            bus.book_valid <= win_books;
                            bus.out_op     <= win_op;
                            state          <= ISSUE;
                        end else begin
                            bus.illegal_err <= 1'b1;
                            bus.req_ready   <= REQ_ONE << win_idx;
                            state           <= ACK;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (book_hit) begin
                        bus.book_valid <= '0;
                        bus.req_ready  <= REQ_ONE << bus.grant_id;
                        state          <= ACK;
                    end else if (wait_cnt == TMO_LAST) begin
                        bus.book_valid  <= '0;
                        bus.timeout_err <= 1'b1;
                        bus.req_ready   <= REQ_ONE << bus.grant_id;
                        state           <= ACK;
                    end
                end
                ACK: begin
                    wait_cnt <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    wait_cnt <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_order_dispatch_arbiter.sv
// Scoreboard bench for order_dispatch_arbiter (NUM_REQ=2, NUM_BOOKS=4,
// TIMEOUT=8). Stimulus pushes expected book issues and requester acks;
// a negedge monitor pops and compares them when the DUT presents them.
module tb_order_dispatch_arbiter;
    typedef struct {
        logic [3:0]  bv;
        logic [2:0]  op;
        logic [0:0]  gid;
        logic [31:0] oid;
        logic [31:0] qty;
        logic [63:0] price;
    } iss_t;

    typedef struct {
        logic [1:0] rr;
        logic       ill;
        logic       tmo;
        int         bvc;
        int         gap;
    } ack_t;

    logic clk;
    logic resetn;
    int   cmp_cnt;
    int   err_cnt;

    iss_t iss_q[$];
    ack_t ack_q[$];

    order_dispatch_arbiter_if #(.NUM_REQ(2), .NUM_BOOKS(4)) ifc ();

    order_dispatch_arbiter #(
        .NUM_REQ  (2),
        .NUM_BOOKS(4),
        .TIMEOUT  (8)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: got %s expected event", nm, why);
    endtask

    // ---------------- monitor ----------------
    iss_t cur;
    logic prev_bv_any;
    logic rst_seen;
    logic busy_chk;
    int   cyc;
    int   bv_cnt;
    int   last_ack;

    initial begin
        prev_bv_any = 1'b0;
        rst_seen    = 1'b0;
        busy_chk    = 1'b0;
        cyc         = 0;
        bv_cnt      = 0;
        last_ack    = 0;
        cur         = '{default: '0};
    end

    always @(negedge clk) begin
        ack_t ea;
        cyc++;
        if (!resetn) begin
            rst_seen    = 1'b1;
            busy_chk    = 1'b0;
            bv_cnt      = 0;
            prev_bv_any = 1'b0;
        end else begin
            if (rst_seen) begin
                check("reset_outputs",
                      160'({ifc.req_ready, ifc.book_valid, ifc.out_order_id, ifc.out_quantity,
                            ifc.out_price, ifc.out_op, ifc.grant_id, ifc.busy,
                            ifc.illegal_err, ifc.timeout_err}), 160'(0));
                rst_seen = 1'b0;
            end
            if (busy_chk) begin
                check("busy_after_ack", 160'(ifc.busy), 160'(0));
                busy_chk = 1'b0;
            end
            if (ifc.book_valid != 4'b0) begin
                bv_cnt++;
                if (!prev_bv_any) begin
                    if (iss_q.size() == 0) fail_now("unexpected_issue", "issue");
                    else cur = iss_q.pop_front();
                end
                check("issue_bus",
                      160'({ifc.book_valid, ifc.out_op, ifc.grant_id, ifc.out_order_id,
                            ifc.out_quantity, ifc.out_price}),
                      160'({cur.bv, cur.op, cur.gid, cur.oid, cur.qty, cur.price}));
            end
            if (ifc.req_ready != 2'b0) begin
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack", "ack");
                end else begin
                    ea = ack_q.pop_front();
                    check("ack_ready_err", 160'({ifc.req_ready, ifc.illegal_err, ifc.timeout_err}),
                          160'({ea.rr, ea.ill, ea.tmo}));
                    if (ea.bvc >= 0) check("ack_bv_cycles", 160'(bv_cnt), 160'(ea.bvc));
                    if (ea.gap >= 0) check("ack_gap", 160'(cyc - last_ack), 160'(ea.gap));
                end
                last_ack = cyc;
                bv_cnt   = 0;
                busy_chk = 1'b1;
            end else if (ifc.illegal_err || ifc.timeout_err) begin
                check("err_without_ack", 160'({ifc.illegal_err, ifc.timeout_err}), 160'(0));
            end
            prev_bv_any = (ifc.book_valid != 4'b0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int r, input logic [11:0] act, input logic [31:0] oid,
                           input logic [31:0] qty, input logic [63:0] pr);
        ifc.req_order_id[32*r +: 32]       = oid;
        ifc.req_quantity[32*r +: 32]       = qty;
        ifc.req_price[64*r +: 64]          = pr;
        ifc.req_stock_activate[12*r +: 12] = act;
        ifc.req_valid[r]                   = 1'b1;
    endtask

    task automatic push_iss(input logic [3:0] bv, input logic [2:0] op, input logic [0:0] gid,
                            input logic [31:0] oid, input logic [31:0] qty, input logic [63:0] pr);
        iss_t e;
        e.bv = bv; e.op = op; e.gid = gid; e.oid = oid; e.qty = qty; e.price = pr;
        iss_q.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] rr, input logic ill, input logic tmo,
                            input int bvc, input int gap);
        ack_t e;
        e.rr = rr; e.ill = ill; e.tmo = tmo; e.bvc = bvc; e.gap = gap;
        ack_q.push_back(e);
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk);
            #1;
            if (ifc.req_ready != 2'b0) got = 1'b1;
        end
        if (!got) fail_now("wait_ack_timeout", "none");
    endtask

    task automatic wait_bv();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk);
            #1;
            if (ifc.book_valid != 4'b0) got = 1'b1;
        end
        if (!got) fail_now("wait_book_valid_timeout", "none");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDE0;

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        resetn                 = 1'b0;
        ifc.req_valid          = '0;
        ifc.req_order_id       = '0;
        ifc.req_quantity       = '0;
        ifc.req_price          = '0;
        ifc.req_stock_activate = '0;
        ifc.book_ready         = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Round robin: both requesters valid, grants 0,1,0,1 every 3 cycles.
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) push_iss(4'b0001, 3'b100, 1'b0, 32'h200 + g, 32'h1000 + g, P0 + 64'(g));
            else            push_iss(4'b1000, 3'b001, 1'b1, 32'h200 + g, 32'h1000 + g, P0 + 64'(g));
            push_ack((g % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 1, (g == 0) ? -1 : 3);
        end
        ifc.book_ready = 4'hF;
        set_req(0, 12'h800, 32'h200, 32'h1000, P0);
        set_req(1, 12'h001, 32'h201, 32'h1001, P0 + 64'd1);
        for (int g = 0; g < 4; g++) begin
            wait_ack();
            if (g < 2) set_req(g % 2, (g % 2 == 0) ? 12'h800 : 12'h001,
                               32'h200 + g + 2, 32'h1000 + g + 2, P0 + 64'(g + 2));
            else ifc.req_valid[g % 2] = 1'b0;
        end
        idle(2);

        // Single legal add to book 0.
        push_iss(4'b0001, 3'b100, 1'b0, 32'h11, 32'h5, 64'h64);
        push_ack(2'b01, 1'b0, 1'b0, 1, -1);
        set_req(0, 12'b1000_0000_0000, 32'h11, 32'h5, 64'h64);
        wait_ack();
        ifc.req_valid[0] = 1'b0;
        idle(2);

        // Illegal: no activate bit.
        push_ack(2'b10, 1'b1, 1'b0, 0, -1);
        set_req(1, 12'h000, 32'h21, 32'h6, 64'h70);
        wait_ack();
        ifc.req_valid[1] = 1'b0;
        idle(2);

        // Illegal: two activate bits.
        push_ack(2'b01, 1'b1, 1'b0, 0, -1);
        set_req(0, 12'b1100_0000_0000, 32'h22, 32'h7, 64'h71);
        wait_ack();
        ifc.req_valid[0] = 1'b0;
        idle(2);

        // Late book: delete to book 1, other books ready but ignored.
        ifc.book_ready = 4'b1101;
        push_iss(4'b0010, 3'b010, 1'b1, 32'hDEAD_0001, 32'h40, 64'hFEED_0000_0000_0042);
        push_ack(2'b10, 1'b0, 1'b0, 5, -1);
        set_req(1, 12'b0000_1000_0000, 32'hDEAD_0001, 32'h40, 64'hFEED_0000_0000_0042);
        wait_bv();
        idle(4);
        ifc.book_ready = 4'hF;
        wait_ack();
        ifc.req_valid[1] = 1'b0;
        idle(2);

        // Timeout: add to book 3, book 3 never ready.
        ifc.book_ready = 4'b0111;
        push_iss(4'b1000, 3'b100, 1'b0, 32'h55, 32'h9, 64'h99);
        push_ack(2'b01, 1'b0, 1'b1, 8, -1);
        set_req(0, 12'b0000_0000_0100, 32'h55, 32'h9, 64'h99);
        wait_ack();
        ifc.req_valid[0] = 1'b0;
        idle(2);

        // Reset while book 2 is being offered a command; no ack expected.
        ifc.book_ready = 4'b1011;
        push_iss(4'b0100, 3'b100, 1'b0, 32'h77, 32'hA, 64'hAA);
        set_req(0, 12'b0000_0010_0000, 32'h77, 32'hA, 64'hAA);
        wait_bv();
        idle(1);
        resetn        = 1'b0;
        ifc.req_valid = '0;
        idle(1);
        resetn = 1'b1;
        idle(1);

        // After reset rr_ptr is 0 again: requester 0 wins first.
        ifc.book_ready = 4'hF;
        push_iss(4'b0001, 3'b100, 1'b0, 32'h300, 32'hB, 64'hB0);
        push_ack(2'b01, 1'b0, 1'b0, 1, -1);
        push_iss(4'b0010, 3'b100, 1'b1, 32'h301, 32'hC, 64'hC0);
        push_ack(2'b10, 1'b0, 1'b0, 1, 3);
        set_req(0, 12'b1000_0000_0000, 32'h300, 32'hB, 64'hB0);
        set_req(1, 12'b0001_0000_0000, 32'h301, 32'hC, 64'hC0);
        wait_ack();
        ifc.req_valid[0] = 1'b0;
        wait_ack();
        ifc.req_valid[1] = 1'b0;
        idle(4);

        check("issue_queue_drained", 160'(iss_q.size()), 160'(0));
        check("ack_queue_drained", 160'(ack_q.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
